// File: rtl/digit_pkg.sv
// Shared definitions for the two-digit BCD step controller.
//   - state_e       : sequencer states
//   - UnitsMaxDef   : default highest units-digit value
//   - TensMaxDef    : default highest tens-digit value
//   - DigitW        : width of one BCD digit
package digit_pkg;

  localparam int unsigned DigitW      = 4;
  localparam int unsigned UnitsMaxDef = 9;
  localparam int unsigned TensMaxDef  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StUnits,
    StTens,
    StDone
  } state_e;

endpackage

// File: rtl/bcd_digit_step.sv
// Single-digit +1/-1 step with wrap at a programmable maximum.
// Ports:
//   value : current digit (0..max)
//   dir   : 1 = add, 0 = sub
//   max   : highest legal digit value
//   next  : stepped digit value
//   cy    : carry (add past max) or borrow (sub below 0)
module bcd_digit_step
  import digit_pkg::*;
(
  input  logic [DigitW-1:0] value,
  input  logic              dir,
  input  logic [DigitW-1:0] max,
  output logic [DigitW-1:0] next,
  output logic              cy
);

  always_comb begin
    next = value;
    cy   = 1'b0;
    if (dir) begin
      // >= rather than == keeps an out-of-range value from running away
      if (value < max) begin
        next = value + 1'b1;
      end else begin
        next = '0;
        cy   = 1'b1;
      end
    end else begin
      if (value != '0) begin
        next = value - 1'b1;
      end else begin
        next = max;
        cy   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_seq_ctrl.sv
// Two-digit (tens:units) BCD counter stepped by two requesters through a
// small sequencer: IDLE grants a request, UNITS steps the units digit,
// TENS (only on carry/borrow) steps the tens digit, DONE signals completion.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : synchronous clear of digits and sequencer
//   req_a, dir_a   : requester A level request and direction (1 = +1)
//   req_b, dir_b   : requester B level request and direction (1 = +1)
//   ack_a, ack_b   : one-cycle grant pulses, issued in IDLE
//   units, tens    : BCD digits
//   busy           : high outside IDLE
//   done           : one-cycle pulse when a step completes
//   wrap           : one-cycle pulse with done when the count wraps
module digit_seq_ctrl
  import digit_pkg::*;
#(
  parameter int unsigned UNITS_MAX = UnitsMaxDef,
  parameter int unsigned TENS_MAX  = TensMaxDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_a,
  input  logic              dir_a,
  input  logic              req_b,
  input  logic              dir_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DigitW-1:0] units,
  output logic [DigitW-1:0] tens,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  localparam logic [DigitW-1:0] UnitsMaxW = DigitW'(UNITS_MAX);
  localparam logic [DigitW-1:0] TensMaxW  = DigitW'(TENS_MAX);

  state_e            state_q;
  logic [DigitW-1:0] units_q, tens_q;
  logic              dir_q;
  logic              last_b_q;  // 1 when B was granted most recently
  logic              busy_q, done_q, wrap_q;

  logic              grant_a, grant_b;
  logic [DigitW-1:0] units_next, tens_next;
  logic              units_cy, tens_cy;

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    grant_a = req_a & (~req_b | last_b_q);
    grant_b = req_b & (~req_a | ~last_b_q);
  end

  bcd_digit_step u_units_step (
    .value (units_q),
    .dir   (dir_q),
    .max   (UnitsMaxW),
    .next  (units_next),
    .cy    (units_cy)
  );

  bcd_digit_step u_tens_step (
    .value (tens_q),
    .dir   (dir_q),
    .max   (TensMaxW),
    .next  (tens_next),
    .cy    (tens_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      units_q  <= '0;
      tens_q   <= '0;
      dir_q    <= 1'b0;
      last_b_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (clr) begin
      state_q <= StIdle;
      units_q <= '0;
      tens_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_a || grant_b) begin
            dir_q    <= grant_a ? dir_a : dir_b;
            last_b_q <= grant_b;
            busy_q   <= 1'b1;
            state_q  <= StUnits;
          end
        end
        StUnits: begin
          units_q <= units_next;
          if (units_cy) begin
            state_q <= StTens;
          end else begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StTens: begin
          tens_q  <= tens_next;
          wrap_q  <= tens_cy;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Acks are issued in the IDLE cycle itself; clr masks every pulse in its cycle.
  assign ack_a = (state_q == StIdle) & ~clr & grant_a;
  assign ack_b = (state_q == StIdle) & ~clr & grant_b;
  assign done  = done_q & ~clr;
  assign wrap  = wrap_q & ~clr;
  assign busy  = busy_q;
  assign units = units_q;
  assign tens  = tens_q;

endmodule

// File: tb/tb_digit_seq_ctrl.sv
module tb_digit_seq_ctrl;

  logic       clk, rst_n, clr;
  logic       req_a, dir_a, req_b, dir_b;
  logic       ack_a, ack_b, busy, done, wrap;
  logic [3:0] units, tens;

  int n_checks = 0;
  int n_fail   = 0;

  digit_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .req_a (req_a),
    .dir_a (dir_a),
    .req_b (req_b),
    .dir_b (dir_b),
    .ack_a (ack_a),
    .ack_b (ack_b),
    .units (units),
    .tens  (tens),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1 with the sequencer idle.
  task automatic do_step(input logic use_b, input logic d, input int lat,
                         input logic [3:0] eu, input logic [3:0] et, input logic ew);
    if (use_b) begin
      req_b = 1'b1; dir_b = d;
    end else begin
      req_a = 1'b1; dir_a = d;
    end
    #1;
    chk1("ack_a", ack_a, ~use_b);
    chk1("ack_b", ack_b, use_b);
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    chk1("busy_in_step", busy, 1'b1);
    for (int k = 1; k < lat; k++) begin
      chk1("early_done", done, 1'b0);
      @(posedge clk); #1;
    end
    chk1("done", done, 1'b1);
    chk1("wrap", wrap, ew);
    chk4("units", units, eu);
    chk4("tens", tens, et);
    @(posedge clk); #1;
    chk1("done_one_cycle", done, 1'b0);
    chk1("busy_after", busy, 1'b0);
    chk1("wrap_one_cycle", wrap, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    req_a = 1'b0; dir_a = 1'b0; req_b = 1'b0; dir_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk4("rst_units", units, 4'd0);
    chk4("rst_tens", tens, 4'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_wrap", wrap, 1'b0);
    chk1("rst_ack_a", ack_a, 1'b0);
    chk1("rst_ack_b", ack_b, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0:0 -> 0:1, ack then done two cycles later
    do_step(1'b0, 1'b1, 2, 4'd1, 4'd0, 1'b0);
    // count up to 0:9, alternating single requesters
    for (int i = 2; i <= 9; i++) begin
      do_step(1'(i % 2), 1'b1, 2, 4'(i), 4'd0, 1'b0);
    end
    // carry: 0:9 -> 1:0, three cycles
    do_step(1'b0, 1'b1, 3, 4'd0, 4'd1, 1'b0);
    // borrow: 1:0 -> 0:9
    do_step(1'b1, 1'b0, 3, 4'd9, 4'd0, 1'b0);

    // clr during TENS of a 0:9 -> 1:0 step
    req_a = 1'b1; dir_a = 1'b1;
    #1;
    chk1("clr_pre_ack", ack_a, 1'b1);
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;  // now in TENS, units already 0
    chk4("tens_state_units", units, 4'd0);
    chk1("tens_state_done", done, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk4("clr_units", units, 4'd0);
    chk4("clr_tens", tens, 4'd0);
    chk1("clr_busy", busy, 1'b0);
    chk1("clr_done", done, 1'b0);
    chk1("clr_wrap", wrap, 1'b0);
    @(posedge clk); #1;
    chk1("clr_done_later", done, 1'b0);

    // clr masks an ack in IDLE
    req_a = 1'b1; clr = 1'b1;
    #1;
    chk1("clr_masks_ack", ack_a, 1'b0);
    @(posedge clk); #1;
    chk1("clr_no_grant", busy, 1'b0);
    clr = 1'b0; req_a = 1'b0;

    // wrap cases
    do_step(1'b0, 1'b0, 3, 4'd9, 4'd5, 1'b1);  // 0:0 -> 5:9
    do_step(1'b1, 1'b1, 3, 4'd0, 4'd0, 1'b1);  // 5:9 -> 0:0
    do_step(1'b0, 1'b0, 3, 4'd9, 4'd5, 1'b1);  // 0:0 -> 5:9

    // reset in UNITS abandons the step
    req_a = 1'b1; dir_a = 1'b1;
    #1;
    chk1("rst_step_ack", ack_a, 1'b1);
    @(posedge clk); #1;
    req_a = 1'b0;
    chk1("rst_step_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk4("async_units", units, 4'd0);
    chk4("async_tens", tens, 4'd0);
    chk1("async_busy", busy, 1'b0);
    chk1("async_done", done, 1'b0);
    @(posedge clk); #1;
    chk1("rst_hold_done", done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_done", done, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);

    // tie held: A, B, A, B, each step finishing before the next ack
    req_a = 1'b1; req_b = 1'b1; dir_a = 1'b1; dir_b = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk1("rr_ack_a", ack_a, 1'((g + 1) % 2));
      chk1("rr_ack_b", ack_b, 1'(g % 2));
      @(posedge clk); #1;
      chk1("rr_no_ack_a_busy", ack_a, 1'b0);
      chk1("rr_no_ack_b_busy", ack_b, 1'b0);
      @(posedge clk); #1;
      chk1("rr_done", done, 1'b1);
      chk4("rr_units", units, 4'(g + 1));
      chk1("rr_no_ack_done", ack_a | ack_b, 1'b0);
      @(posedge clk);
    end
    #1;
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk1("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
